// File: rtl/median_result_packer.sv
// Packs median-filter result bits LSB-first into RAM words.
// Tracks bit/ones counts, flags frame completion and late strobes.
module median_result_packer #(
  parameter int OUT_COLS   = 238,
  parameter int OUT_ROWS   = 178,
  parameter int WORD_WIDTH = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  medianValid,
  input  logic                  medianBit,
  output logic                  writeEnable,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic [WORD_WIDTH-1:0] writeData,
  output logic [15:0]           bitCount,
  output logic [15:0]           onesCount,
  output logic                  packDone,
  output logic                  overflowError
);

  localparam int TOTAL = OUT_COLS * OUT_ROWS;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int IW    = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PACK,
    FLUSH,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [15:0]           bit_cnt_q, bit_cnt_d;
  logic [15:0]           ones_q, ones_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [ADDR_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [CW-1:0]         acc_q, acc_d;

  logic [WORD_WIDTH-1:0] word;
  logic                  last;
  logic                  full;

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    bit_cnt_d   = bit_cnt_q;
    ones_d      = ones_q;
    done_d      = done_q;
    ovf_d       = ovf_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    word_addr_d = word_addr_q;
    acc_d       = acc_q;
    word = shift_q | (WORD_WIDTH'(medianBit) << bit_idx_q);
    last = (acc_q == CW'(TOTAL - 1));
    full = (bit_idx_q == IW'(WORD_WIDTH - 1));

    if (!start) begin
      state_d     = IDLE;
      waddr_d     = '0;
      wdata_d     = '0;
      bit_cnt_d   = '0;
      ones_d      = '0;
      done_d      = 1'b0;
      ovf_d       = 1'b0;
      shift_d     = '0;
      bit_idx_d   = '0;
      word_addr_d = '0;
      acc_d       = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = PACK;
        PACK: begin
          if (medianValid) begin
            acc_d = acc_q + CW'(1);
            if (bit_cnt_q != 16'hFFFF)
              bit_cnt_d = bit_cnt_q + 16'd1;
            if (medianBit && ones_q != 16'hFFFF)
              ones_d = ones_q + 16'd1;
            if (full || last) begin
              // Write is registered here so it lands one cycle after the strobe.
              we_d      = 1'b1;
              wdata_d   = word;
              waddr_d   = word_addr_q;
              shift_d   = '0;
              bit_idx_d = '0;
              if (!last)
                word_addr_d = word_addr_q + ADDR_WIDTH'(1);
              if (last)
                state_d = full ? DONE : FLUSH;
            end else begin
              shift_d   = word;
              bit_idx_d = bit_idx_q + IW'(1);
            end
          end
        end
        FLUSH: begin
          done_d  = 1'b1;
          state_d = DONE;
          if (medianValid)
            ovf_d = 1'b1;
        end
        DONE: begin
          done_d = 1'b1;
          if (medianValid)
            ovf_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      bit_cnt_q   <= '0;
      ones_q      <= '0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      word_addr_q <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      bit_cnt_q   <= bit_cnt_d;
      ones_q      <= ones_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      word_addr_q <= word_addr_d;
      acc_q       <= acc_d;
    end
  end

  assign writeEnable   = we_q;
  assign writeAddress  = waddr_q;
  assign writeData     = wdata_q;
  assign bitCount      = bit_cnt_q;
  assign onesCount     = ones_q;
  assign packDone      = done_q;
  assign overflowError = ovf_q;

endmodule

// File: tb/tb_median_result_packer.sv
// Bench for median_result_packer: vector table, directed frames
// and randomized strobes against a bit-list reference model.
module tb_median_result_packer;

  localparam int TOTAL = 238 * 178;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        medianValid = 1'b0;
  logic        medianBit = 1'b0;
  logic        writeEnable;
  logic [12:0] writeAddress;
  logic [7:0]  writeData;
  logic [15:0] bitCount;
  logic [15:0] onesCount;
  logic        packDone;
  logic        overflowError;

  median_result_packer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .medianValid(medianValid),
    .medianBit(medianBit),
    .writeEnable(writeEnable),
    .writeAddress(writeAddress),
    .writeData(writeData),
    .bitCount(bitCount),
    .onesCount(onesCount),
    .packDone(packDone),
    .overflowError(overflowError)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the list of bits accepted in the current frame.
  bit bits_q[$];
  int ones_m;
  bit armed;
  bit fin;
  int fin_age;
  bit ovf_m;

  int wr_cnt;
  int ff_cnt;
  int w55_cnt;
  int last_addr;
  int last_data;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    bits_q.delete();
    ones_m  = 0;
    armed   = 1'b0;
    fin     = 1'b0;
    fin_age = 0;
    ovf_m   = 1'b0;
  endtask

  task automatic tick(input bit s, input bit v, input bit b);
    bit        exp_we;
    int        w;
    int        n;
    logic [7:0] ed;
    start       = s;
    medianValid = v;
    medianBit   = b;
    @(posedge clk);
    #1;
    exp_we = 1'b0;
    w      = 0;
    ed     = '0;
    if (!s) begin
      model_clear();
    end else if (!armed) begin
      armed = 1'b1;
    end else if (!fin) begin
      if (v) begin
        bits_q.push_back(b);
        ones_m += int'(b);
        n = bits_q.size();
        if (n % 8 == 0 || n == TOTAL) begin
          exp_we = 1'b1;
          w = (n - 1) / 8;
          for (int j = 0; j < 8; j++)
            if (8 * w + j < n) ed[j] = bits_q[8 * w + j];
        end
        if (n == TOTAL) begin
          fin     = 1'b1;
          fin_age = 0;
        end
      end
    end else begin
      fin_age++;
      if (v) ovf_m = 1'b1;
    end
    chk("writeEnable", int'(writeEnable), int'(exp_we));
    if (exp_we) begin
      chk("writeAddress", int'(writeAddress), w);
      chk("writeData", int'(writeData), int'(ed));
    end
    if (writeEnable) begin
      wr_cnt++;
      last_addr = int'(writeAddress);
      last_data = int'(writeData);
      if (writeData == 8'hFF) ff_cnt++;
      if (writeData == 8'h55) w55_cnt++;
    end
    n = bits_q.size();
    chk("bitCount", int'(bitCount), n > 65535 ? 65535 : n);
    chk("onesCount", int'(onesCount), ones_m > 65535 ? 65535 : ones_m);
    chk("packDone", int'(packDone), int'(fin && fin_age >= 1));
    chk("overflowError", int'(overflowError), int'(ovf_m));
  endtask

  task automatic restart();
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    wr_cnt  = 0;
    ff_cnt  = 0;
    w55_cnt = 0;
  endtask

  typedef struct {
    logic [7:0] arrival;
    logic [7:0] exp_data;
    int         exp_ones;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // arrival is written first-bit-leftmost
    vecs[0] = '{8'b1011_0001, 8'h8D, 4};
    vecs[1] = '{8'b1111_1111, 8'hFF, 8};
    vecs[2] = '{8'b0000_0000, 8'h00, 0};
    vecs[3] = '{8'b1000_0000, 8'h01, 1};
    vecs[4] = '{8'b0000_0001, 8'h80, 1};
    vecs[5] = '{8'b1111_0000, 8'h0F, 4};
    vecs[6] = '{8'b0101_0101, 8'hAA, 4};

    model_clear();
    reset = 1'b1;
    #12;
    chk("rst_writeEnable", int'(writeEnable), 0);
    chk("rst_bitCount", int'(bitCount), 0);
    chk("rst_packDone", int'(packDone), 0);
    reset = 1'b0;

    // Async reset in mid-frame.
    restart();
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    #2;
    chk("arst_bitCount", int'(bitCount), 0);
    chk("arst_onesCount", int'(onesCount), 0);
    chk("arst_writeAddress", int'(writeAddress), 0);
    chk("arst_writeData", int'(writeData), 0);
    chk("arst_writeEnable", int'(writeEnable), 0);
    model_clear();
    #2;
    reset = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'(i & 1));
    chk("arst_next_addr", int'(writeAddress), 0);
    chk("arst_next_we", int'(writeEnable), 1);

    // Vector table, each in a fresh frame.
    for (int k = 0; k < 7; k++) begin
      logic [7:0] a;
      a = vecs[k].arrival;
      restart();
      for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, a[7-i]);
      chk("vec_we", int'(writeEnable), 1);
      chk("vec_addr", int'(writeAddress), 0);
      chk("vec_data", int'(writeData), int'(vecs[k].exp_data));
      chk("vec_bits", int'(bitCount), 8);
      chk("vec_ones", int'(onesCount), vecs[k].exp_ones);
    end

    // Full frame of ones, back-to-back.
    restart();
    for (int i = 0; i < TOTAL; i++) tick(1'b1, 1'b1, 1'b1);
    chk("ones_last_data", last_data, 8'h0F);
    chk("ones_last_addr", last_addr, 5295);
    tick(1'b1, 1'b0, 1'b0);
    chk("ones_wr_cnt", wr_cnt, 5296);
    chk("ones_ff_cnt", ff_cnt, 5295);
    chk("ones_done", int'(packDone), 1);
    chk("ones_bitCount", int'(bitCount), 42364);
    chk("ones_onesCount", int'(onesCount), 42364);

    // Late strobe after completion.
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
    chk("ovf_flag", int'(overflowError), 1);
    chk("ovf_done", int'(packDone), 1);
    chk("ovf_wr_cnt", wr_cnt, 5296);

    // Alternating frame with random idle gaps.
    restart();
    for (int i = 0; i < TOTAL; i++) begin
      if (i % 64 == 0 || i > TOTAL - 40)
        repeat ($urandom_range(0, 5)) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'((i + 1) & 1));
    end
    chk("alt_last_data", last_data, 8'h05);
    tick(1'b1, 1'b0, 1'b0);
    chk("alt_wr_cnt", wr_cnt, 5296);
    chk("alt_55_cnt", w55_cnt, 5295);
    chk("alt_onesCount", int'(onesCount), 21182);
    chk("alt_done", int'(packDone), 1);

    // Abort after 100 random strobes, then restart.
    restart();
    for (int i = 0; i < 100; i++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    tick(1'b0, 1'b0, 1'b0);
    chk("abort_bitCount", int'(bitCount), 0);
    chk("abort_onesCount", int'(onesCount), 0);
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'($urandom_range(0, 1)));
    chk("abort_we", int'(writeEnable), 1);
    chk("abort_addr", int'(writeAddress), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
